// File: rtl/word_packer_pkg.sv
// Shared definitions for the word packer and the 4-input adder stage it feeds.
// Holds the state encoding, lane count and the default datapath parameters.
package word_packer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int LANES             = 4;
    localparam int DEFAULT_WIDTH     = 25;
    localparam int DEFAULT_ADDER_LAT = 2;

endpackage

// File: rtl/valid_delay.sv
// One-bit shift line of DEPTH flops, used to align a valid strobe with a
// pipelined datapath of the same latency.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line <= '0;
        end else begin
            line[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign q = line[DEPTH-1];

endmodule

// File: rtl/word_packer.sv
// Packs a serial stream of signed words into groups of four for the adder
// stage, with zero padding on flush and a latency-matched sum strobe.
module word_packer
    import word_packer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int ADDER_LAT = DEFAULT_ADDER_LAT,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] word_0,
    output logic signed [WIDTH-1:0] word_1,
    output logic signed [WIDTH-1:0] word_2,
    output logic signed [WIDTH-1:0] word_3,
    output logic                    group_valid,
    output logic                    sum_valid,
    output logic [CNT_W-1:0]        group_cnt,
    output logic [2:0]              fill_lvl
);

    state_t                  state;
    logic signed [WIDTH-1:0] slot [LANES-1];
    logic                    accept;
    logic                    write_slot;
    logic                    emit;
    logic signed [WIDTH-1:0] slot_data;

    // The last slot never needs storage: the completing word goes straight
    // into the output registers, so groups can run back to back.
    always_comb begin
        in_ready   = !rst && (state != PAD);
        accept     = in_valid && in_ready;
        write_slot = (state == PAD) || accept;
        slot_data  = (state == PAD) ? '0 : in_data;
        emit       = write_slot && (fill_lvl == 3'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            fill_lvl    <= '0;
            group_cnt   <= '0;
            group_valid <= 1'b0;
            word_0      <= '0;
            word_1      <= '0;
            word_2      <= '0;
            word_3      <= '0;
            for (int i = 0; i < LANES - 1; i++) begin
                slot[i] <= '0;
            end
        end else begin
            group_valid <= emit;
            if (emit) begin
                word_0    <= slot[0];
                word_1    <= slot[1];
                word_2    <= slot[2];
                word_3    <= slot_data;
                group_cnt <= group_cnt + CNT_W'(1);
                fill_lvl  <= '0;
                state     <= IDLE;
            end else if (write_slot) begin
                for (int i = 0; i < LANES - 1; i++) begin
                    if (fill_lvl == 3'(i)) begin
                        slot[i] <= slot_data;
                    end
                end
                fill_lvl <= fill_lvl + 3'd1;
                // A flush arriving with a word pads whatever slots remain.
                state    <= ((state == PAD) || flush) ? PAD : FILL;
            end else if (flush && (state == FILL)) begin
                state <= PAD;
            end
        end
    end

    valid_delay #(
        .DEPTH(ADDER_LAT)
    ) u_sum_delay (
        .clk(clk),
        .rst(rst),
        .d  (group_valid),
        .q  (sum_valid)
    );

endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench for word_packer: a group-level model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_word_packer;

    logic               clk;
    logic               rst;
    logic signed [24:0] in_data;
    logic               in_valid;
    logic               flush;
    logic               in_ready;
    logic signed [24:0] word_0, word_1, word_2, word_3;
    logic               group_valid;
    logic               sum_valid;
    logic [15:0]        group_cnt;
    logic [2:0]         fill_lvl;

    logic               in_ready_n;
    logic signed [24:0] word_0_n, word_1_n, word_2_n, word_3_n;
    logic               group_valid_n;
    logic               sum_valid_n;
    logic [1:0]         group_cnt_n;
    logic [2:0]         fill_lvl_n;

    int n_checks = 0;
    int n_pass   = 0;

    word_packer dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush),
        .word_0(word_0), .word_1(word_1), .word_2(word_2), .word_3(word_3),
        .group_valid(group_valid), .sum_valid(sum_valid),
        .group_cnt(group_cnt), .fill_lvl(fill_lvl)
    );

    word_packer #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_n), .flush(flush),
        .word_0(word_0_n), .word_1(word_1_n), .word_2(word_2_n), .word_3(word_3_n),
        .group_valid(group_valid_n), .sum_valid(sum_valid_n),
        .group_cnt(group_cnt_n), .fill_lvl(fill_lvl_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic v, input longint d, input logic f);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = 25'(d);
        flush    = f;
    endtask

    // Group-level model: a queue of words collected so far for the open group.
    longint exp_w [4];
    longint grp [$];
    bit     padding;
    bit     exp_gv, exp_sv, gv_d1;
    int     exp_cnt;

    task automatic resetModel();
        grp.delete();
        padding = 0;
        exp_gv  = 0;
        exp_sv  = 0;
        gv_d1   = 0;
        exp_cnt = 0;
        foreach (exp_w[i]) exp_w[i] = 0;
    endtask

    // Compare at negedge, then predict the effect of the coming posedge
    // from the inputs that will be sampled there.
    initial begin
        bit was_pad;
        bit acc;
        bit next_sv;
        resetModel();
        forever begin
            @(negedge clk);
            if (rst) resetModel();
            checkOutput("in_ready", longint'(in_ready), longint'(!rst && !padding));
            checkOutput("word_0", longint'(word_0), exp_w[0]);
            checkOutput("word_1", longint'(word_1), exp_w[1]);
            checkOutput("word_2", longint'(word_2), exp_w[2]);
            checkOutput("word_3", longint'(word_3), exp_w[3]);
            checkOutput("group_valid", longint'(group_valid), longint'(exp_gv));
            checkOutput("sum_valid", longint'(sum_valid), longint'(exp_sv));
            checkOutput("group_cnt", longint'(group_cnt), longint'(exp_cnt % 65536));
            checkOutput("group_cnt_narrow", longint'(group_cnt_n), longint'(exp_cnt % 4));
            checkOutput("fill_lvl", longint'(fill_lvl), longint'(grp.size()));
            if (!rst) begin
                was_pad = padding;
                acc     = in_valid && !padding;
                next_sv = gv_d1;
                gv_d1   = exp_gv;
                exp_gv  = 0;
                if (was_pad) begin
                    grp.push_back(0);
                end else begin
                    if (acc) grp.push_back(longint'(in_data));
                    if (flush && grp.size() > 0 && grp.size() < 4) padding = 1;
                end
                if (grp.size() == 4) begin
                    foreach (exp_w[i]) exp_w[i] = grp[i];
                    grp.delete();
                    padding = 0;
                    exp_gv  = 1;
                    exp_cnt++;
                end
                exp_sv = next_sv;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wrap_seq [5];
        wrap_seq = '{1, 2, 3, 0, 1};
        rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single group 1,2,3,4.
        for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0);
        applyStimulus(0, 0, 0);
        checkOutput("lit_gv_first", longint'(group_valid), 1);
        checkOutput("lit_w0_first", longint'(word_0), 1);
        checkOutput("lit_w3_first", longint'(word_3), 4);
        checkOutput("lit_cnt_first", longint'(group_cnt), 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("lit_sv_first", longint'(sum_valid), 1);

        // Continuous stream 1..12.
        for (int i = 1; i <= 12; i++) applyStimulus(1, i, 0);
        applyStimulus(0, 0, 0);
        checkOutput("lit_w0_stream", longint'(word_0), 9);
        checkOutput("lit_cnt_stream", longint'(group_cnt), 4);
        repeat (3) applyStimulus(0, 0, 0);

        // -5,7 then flush alone; a word offered during PAD is refused.
        applyStimulus(1, -5, 0);
        applyStimulus(1, 7, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(1, 99, 0);
        checkOutput("lit_ready_pad", longint'(in_ready), 0);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("lit_w0_pad", longint'(word_0), -5);
        checkOutput("lit_w1_pad", longint'(word_1), 7);
        checkOutput("lit_w2_pad", longint'(word_2), 0);
        checkOutput("lit_fill_pad", longint'(fill_lvl), 0);
        repeat (2) applyStimulus(0, 0, 0);

        // 9,9,9 then 9 with flush; then flush at empty.
        repeat (3) applyStimulus(1, 9, 0);
        applyStimulus(1, 9, 1);
        applyStimulus(0, 0, 1);
        checkOutput("lit_w3_nines", longint'(word_3), 9);
        checkOutput("lit_ready_nines", longint'(in_ready), 1);
        applyStimulus(0, 0, 0);
        checkOutput("lit_fill_noflush", longint'(fill_lvl), 0);
        repeat (3) applyStimulus(0, 0, 0);

        // Reset in the middle of a pad.
        applyStimulus(1, 3, 0);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("lit_rst_ready", longint'(in_ready), 0);
        checkOutput("lit_rst_cnt", longint'(group_cnt), 0);
        checkOutput("lit_rst_w0", longint'(word_0), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(1, i * 10, 0);
        applyStimulus(0, 0, 0);
        checkOutput("lit_w0_after_rst", longint'(word_0), 10);
        checkOutput("lit_w3_after_rst", longint'(word_3), 40);
        checkOutput("lit_cnt_after_rst", longint'(group_cnt), 1);

        // Narrow counter wrap over five groups after a fresh reset.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1, g * 4 + i - 7, 0);
            applyStimulus(0, 0, 0);
            checkOutput("lit_cnt_wrap", longint'(group_cnt_n), longint'(wrap_seq[g]));
        end
        repeat (4) applyStimulus(0, 0, 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Upstream feeder for the 4-input pipelined adder stage.
- Accepts a serial stream of signed 25-bit words through a valid/ready handshake and packs 4 consecutive words into a parallel group.
- Presents the group on WORD_0..WORD_3, held stable until the next group is complete.
- Emits GROUP_VALID when a new group is presented, plus SUM_VALID delayed to match the adder's 2-cycle latency, so downstream logic knows which RES cycle is fresh.
- Supports FLUSH, which zero-pads a partial group.

Parameters:
- WIDTH, 25, data word width in bits (signed).
- ADDER_LAT, 2, latency in cycles from WORD_x change to the adder's RES update; sets the SUM_VALID delay.
- CNT_W, 16, width of the GROUP_CNT counter.

Ports:
- CLK  input  1  clock; all state changes on posedge.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  WIDTH  signed input word.
- IN_VALID  input  1  IN_DATA is valid this cycle.
- IN_READY  output  1  block can accept a word this cycle.
- FLUSH  input  1  single-cycle request to complete a partial group with zeros.
- WORD_0  output  WIDTH  first word of the group (oldest), registered.
- WORD_1  output  WIDTH  second word of the group, registered.
- WORD_2  output  WIDTH  third word of the group, registered.
- WORD_3  output  WIDTH  fourth word of the group (newest), registered.
- GROUP_VALID  output  1  one-cycle pulse in the cycle WORD_x first shows a new group.
- SUM_VALID  output  1  GROUP_VALID delayed by ADDER_LAT cycles.
- GROUP_CNT  output  CNT_W  number of groups emitted; wraps modulo 2^CNT_W.
- FILL_LVL  output  3  words currently held in the partial group (0..3).

Behaviour:
- Reset (asynchronous, RST high):
  - state=IDLE, FILL_LVL=0, GROUP_CNT=0.
  - WORD_0..3=0, GROUP_VALID=0, SUM_VALID delay line all 0.
  - IN_READY forced 0 while RST is high.
  - Reset mid-group discards the partial words; reset mid-PAD aborts the pad and emits no group.
- Handshake:
  - A word is accepted iff IN_VALID && IN_READY at posedge.
  - IN_READY=1 in IDLE and FILL, 0 in PAD (and during reset).
  - IN_DATA is ignored when not accepted.
- States:
  - IDLE: FILL_LVL=0. An accept stores into slot 0, FILL_LVL=1, next state FILL.
  - FILL: an accept stores into slot FILL_LVL.
    - If that was slot 3: copy slots 0..3 to WORD_0..3 at that posedge, GROUP_VALID=1 next cycle, GROUP_CNT+1, FILL_LVL=0, next state IDLE.
    - Otherwise FILL_LVL+1.
  - PAD: each cycle writes 0 into slot FILL_LVL.
    - When slot 3 is written, emit the group exactly as in FILL and return to IDLE.
    - One pad slot per cycle; no words are accepted.
- Group emission:
  - Throughput: one word per cycle sustained, so back-to-back groups every 4 cycles with no stall.
  - Emission uses the output registers, so the 4th word of a group and the 1st word of the next are accepted in consecutive cycles.
  - WORD_0..3 change only on emission; otherwise they hold.
- FLUSH:
  - Sampled only in IDLE/FILL; ignored in PAD and during reset.
  - FLUSH with FILL_LVL=0 and no accept in the same cycle: no effect.
  - FLUSH and an accept in the same cycle: the word is stored first, then the flush applies to the remaining slots.
    - If that word completes the group, emit normally and do not enter PAD.
    - Otherwise enter PAD.
  - Example: FILL_LVL=1, accept plus FLUSH -> slots 0,1 hold data; PAD zeros slots 2,3 over 2 cycles; GROUP_VALID follows.
- SUM_VALID: a shift register of ADDER_LAT flops fed by GROUP_VALID; it is high exactly in the cycle RES reflects the new group.
- Arithmetic: no arithmetic on data; words are stored bit-exact, signed. GROUP_CNT wraps from 2^CNT_W-1 to 0 silently.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE=0, FILL=1, PAD=2);
  - constant LANES=4;
  - default WIDTH=25 and ADDER_LAT=2, shared with the adder stage.
- One sub-module is natural: valid_delay (parameterised 1-bit shift line, depth ADDER_LAT, async reset), used for SUM_VALID.

Test Plan:
- Reset, then stream 1,2,3,4 on 4 consecutive cycles -> WORD_0..3 = 1,2,3,4; GROUP_VALID one cycle after the 4th accept; SUM_VALID 2 cycles later; GROUP_CNT=1.
- Continuous stream 1..12 with IN_VALID held high -> 3 groups, GROUP_VALID every 4 cycles, IN_READY never low; WORD_x holds between pulses.
- Stream -5,7 then FLUSH alone -> PAD for 2 cycles with IN_READY=0; group = -5,7,0,0; a word offered during PAD is not accepted.
- Stream 9,9,9 then accept 9 with FLUSH in the same cycle -> group 9,9,9,9, no PAD entry; FLUSH at FILL_LVL=0 with no accept -> no group.
- Assert RST mid-PAD -> all outputs 0 immediately, no GROUP_VALID; the next 4 words form a clean group.
- Preload GROUP_CNT near wrap (CNT_W=2, 5 groups) -> count sequence 1,2,3,0,1.
